// File: rtl/psys_route_pkg.sv
// psys_route_pkg: shared constants, state type and grant encoding for the psys routing blocks
package psys_route_pkg;
  localparam int PSYS_DATA_W = 1536;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} route_arb_state_t;
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S0 = 2'b01;
  localparam logic [1:0] GRANT_S1 = 2'b10;
  function automatic logic [1:0] grant_of(input route_arb_state_t s);
    return s == OWN0 ? GRANT_S0 : s == OWN1 ? GRANT_S1 : GRANT_NONE;
  endfunction
endpackage

// File: rtl/route_out_reg.sv
// route_out_reg: single-entry output register stage with valid/ready handshake, data, last and tag
module route_out_reg
  import psys_route_pkg::*;
#(
  parameter int DATA_W = PSYS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_tag
);
  assign in_ready = ~out_valid | out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_tag <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data <= in_data;
      out_last <= in_last;
      out_tag <= in_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: rtl/psys_route_arb.sv
// psys_route_arb: packet-level arbiter sharing the converter input between activation (s0)
// and weight (s1) streams; counts packets and flags odd-length packets.
module psys_route_arb
  import psys_route_pkg::*;
#(
  parameter int DATA_W = PSYS_DATA_W,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic              s0_axis_tlast,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic              s1_axis_tlast,
  input  logic              s1_weight_switch,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_weight_switch,
  input  logic              cfg_weight_prio,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              err_odd
);
  route_arb_state_t state, state_nxt;
  logic last_grant, parity, sel_valid, sel_last, sel_tag, in_ready, acc, pkt_end;
  logic [DATA_W-1:0] sel_data;
  assign sel_valid = (state == OWN0 && s0_axis_tvalid) || (state == OWN1 && s1_axis_tvalid);
  assign sel_data = state == OWN1 ? s1_axis_tdata : s0_axis_tdata;
  assign sel_last = state == OWN1 ? s1_axis_tlast : s0_axis_tlast;
  assign sel_tag = state == OWN1 && s1_weight_switch;
  assign s0_axis_tready = state == OWN0 && in_ready;
  assign s1_axis_tready = state == OWN1 && in_ready;
  assign acc = sel_valid && in_ready;
  assign pkt_end = acc && sel_last;
  assign grant = grant_of(state);
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = s0_axis_tvalid && s1_axis_tvalid ? (cfg_weight_prio || !last_grant ? OWN1 : OWN0)
                : s0_axis_tvalid ? OWN0 : s1_axis_tvalid ? OWN1 : IDLE;
    else if (pkt_end)
      state_nxt = IDLE;
  end
  // parity still 0 when tlast is accepted means the packet had an odd number of beats
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      parity <= 1'b0;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      err_odd <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pkt_end) begin
        last_grant <= state == OWN1;
        parity <= 1'b0;
        err_odd <= err_odd | ~parity;
        if (state == OWN0) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
        else pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end else if (acc) begin
        parity <= ~parity;
      end
    end
  route_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(sel_valid),
    .in_ready(in_ready),
    .in_data(sel_data),
    .in_last(sel_last),
    .in_tag(sel_tag),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data(m_axis_tdata),
    .out_last(m_axis_tlast),
    .out_tag(m_weight_switch)
  );
endmodule

// File: tb/tb_psys_route_arb.sv
// tb_psys_route_arb: directed scenarios plus a randomized run against a packet-level reference model
module tb_psys_route_arb;
  import psys_route_pkg::*;
  localparam int DW = PSYS_DATA_W;
  localparam int CW = 16;
  typedef struct {
    logic [DW-1:0] d;
    logic l;
    logic t;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic s0_valid, s0_ready, s0_last, s1_valid, s1_ready, s1_last, s1_ws;
  logic m_valid, m_ready, m_last, m_ws, cfg_prio, err_odd;
  logic [1:0] grant;
  logic [CW-1:0] cnt0, cnt1;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  psys_route_arb #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axis_tdata(s0_data), .s0_axis_tvalid(s0_valid), .s0_axis_tready(s0_ready), .s0_axis_tlast(s0_last),
    .s1_axis_tdata(s1_data), .s1_axis_tvalid(s1_valid), .s1_axis_tready(s1_ready), .s1_axis_tlast(s1_last),
    .s1_weight_switch(s1_ws),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last),
    .m_weight_switch(m_ws), .cfg_weight_prio(cfg_prio), .grant(grant),
    .pkt_cnt0(cnt0), .pkt_cnt1(cnt1), .err_odd(err_odd)
  );
  function automatic logic [DW-1:0] rnd_wide();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction
  task automatic idle_in();
    s0_valid = 0; s1_valid = 0; s0_last = 0; s1_last = 0; s1_ws = 0;
    s0_data = '0; s1_data = '0;
  endtask
  task automatic do_reset();
    rst_n = 0; idle_in(); m_ready = 1; cfg_prio = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  // presents one beat from a negedge and returns at the negedge after it was accepted
  task automatic push(input int src, input logic [DW-1:0] d, input logic l, input logic w, output int cyc);
    logic acc;
    bit done;
    done = 0;
    cyc = 0;
    if (src == 0) begin s0_valid = 1; s0_data = d; s0_last = l; end
    else begin s1_valid = 1; s1_data = d; s1_last = l; s1_ws = w; end
    for (int k = 0; k < 40 && !done; k++) begin
      #1 acc = src == 0 ? s0_ready : s1_ready;
      @(negedge clk);
      cyc++;
      done = acc;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL push_timeout src=%0d got no tready in 40 cycles", src); end
  endtask

  task automatic test_reset();
    idle_in(); m_ready = 1; cfg_prio = 0;
    #1 rst_n = 0;
    #1;
    checks++;
    if ({m_valid, m_last, m_ws, s0_ready, s1_ready, grant, err_odd} !== 8'b0 || m_data !== '0 || cnt0 !== '0 || cnt1 !== '0) begin
      errors++; $display("FAIL reset_async got v=%b l=%b g=%b c0=%0d c1=%0d err=%b need all zero", m_valid, m_last, grant, cnt0, cnt1, err_odd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || m_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle got g=%b v=%b r0=%b r1=%b need 00 0 0 0", grant, m_valid, s0_ready, s1_ready);
    end
  endtask

  task automatic test_single_pkt();
    int cyc;
    do_reset();
    for (int b = 1; b <= 4; b++) begin
      push(0, DW'(b), b == 4, 0, cyc);
      checks++;
      if (m_valid !== 1'b1 || m_data !== DW'(b) || m_last !== (b == 4) || m_ws !== 1'b0) begin
        errors++; $display("FAIL single_beat%0d got v=%b d=%0h l=%b ws=%b need 1 %0h %b 0", b, m_valid, m_data[63:0], m_last, m_ws, b, b == 4);
      end
      checks++;
      if (cyc !== (b == 1 ? 2 : 1)) begin
        errors++; $display("FAIL single_latency%0d got %0d cycles need %0d", b, cyc, b == 1 ? 2 : 1);
      end
    end
    s0_valid = 0;
    checks++;
    if (cnt0 !== 16'd1 || err_odd !== 1'b0 || grant !== 2'b00) begin
      errors++; $display("FAIL single_end got c0=%0d err=%b g=%b need 1 0 00", cnt0, err_odd, grant);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drop got v=%b need 0", m_valid); end
  endtask

  task automatic test_round_robin();
    int cyc0, cyc1, nb, code, ecode, k;
    logic [1:0] pg;
    logic [1:0] gorder[$];
    int got_code[$];
    logic got_ws[$], got_last[$];
    do_reset();
    fork
      begin
        for (int p = 0; p < 4; p++)
          for (int b = 0; b < 2; b++) push(0, DW'(p * 10 + b), b == 1, 0, cyc0);
        s0_valid = 0;
      end
      begin
        for (int p = 0; p < 4; p++)
          for (int b = 0; b < 2; b++) push(1, DW'(100 + p * 10 + b), b == 1, b == 1, cyc1);
        s1_valid = 0;
      end
      begin
        pg = 2'b00; nb = 0;
        for (int c = 0; c < 120 && nb < 16; c++) begin
          @(negedge clk);
          #2;
          if (grant != 2'b00 && grant !== pg) gorder.push_back(grant);
          pg = grant;
          if (m_valid) begin
            got_code.push_back(int'(m_data[15:0])); got_ws.push_back(m_ws); got_last.push_back(m_last); nb++;
          end
        end
      end
    join
    checks++;
    if (gorder.size() !== 8) begin errors++; $display("FAIL rr_arbs got %0d arbitrations need 8", gorder.size()); end
    for (int i = 0; i < gorder.size() && i < 8; i++) begin
      checks++;
      if (gorder[i] !== (i % 2 == 0 ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_order%0d got %b need %b", i, gorder[i], i % 2 == 0 ? 2'b01 : 2'b10);
      end
    end
    checks++;
    if (got_code.size() !== 16) begin errors++; $display("FAIL rr_beats got %0d beats need 16", got_code.size()); end
    k = 0;
    for (int p = 0; p < 4; p++)
      for (int s = 0; s < 2; s++)
        for (int b = 0; b < 2; b++) begin
          if (k < got_code.size()) begin
            ecode = s * 100 + p * 10 + b;
            code = got_code[k];
            checks++;
            if (code !== ecode || got_ws[k] !== (s == 1 && b == 1) || got_last[k] !== (b == 1)) begin
              errors++; $display("FAIL rr_beat%0d got code=%0d ws=%b l=%b need %0d %b %b", k, code, got_ws[k], got_last[k], ecode, s == 1 && b == 1, b == 1);
            end
          end
          k++;
        end
    checks++;
    if (cnt0 !== 16'd4 || cnt1 !== 16'd4) begin errors++; $display("FAIL rr_counts got %0d/%0d need 4/4", cnt0, cnt1); end
  endtask

  task automatic test_prio();
    int cyc;
    do_reset();
    cfg_prio = 1;
    s0_valid = 1; s0_data = DW'(7); s0_last = 1;
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 2; b++) begin
        push(1, DW'(p * 2 + b), b == 1, 0, cyc);
        if (b == 0) begin
          checks++;
          if (grant !== 2'b10 || s0_ready !== 1'b0) begin
            errors++; $display("FAIL prio_grant%0d got g=%b r0=%b need 10 0", p, grant, s0_ready);
          end
        end
      end
    s1_valid = 0; s0_valid = 0;
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd3) begin errors++; $display("FAIL prio_counts got %0d/%0d need 0/3", cnt0, cnt1); end
  endtask

  task automatic test_stall();
    int cyc;
    logic [DW-1:0] a, b;
    a = rnd_wide(); b = rnd_wide();
    do_reset();
    push(1, a, 0, 0, cyc);
    checks++;
    if (m_valid !== 1'b1 || m_data !== a || m_ws !== 1'b0 || s0_ready !== 1'b0) begin
      errors++; $display("FAIL stall_first got v=%b d=%0h ws=%b r0=%b need 1 %0h 0 0", m_valid, m_data[63:0], m_ws, s0_ready, a[63:0]);
    end
    s1_data = b; s1_last = 1; s1_ws = 1; m_ready = 0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== a || m_ws !== 1'b0 || s1_ready !== 1'b0 || s0_ready !== 1'b0) begin
      errors++; $display("FAIL stall_hold got v=%b d=%0h ws=%b r1=%b r0=%b need 1 %0h 0 0 0", m_valid, m_data[63:0], m_ws, s1_ready, s0_ready, a[63:0]);
    end
    m_ready = 1;
    @(negedge clk);
    s1_valid = 0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== b || m_ws !== 1'b1 || m_last !== 1'b1 || s0_ready !== 1'b0 || cnt1 !== 16'd1) begin
      errors++; $display("FAIL stall_second got v=%b d=%0h ws=%b l=%b r0=%b c1=%0d need 1 %0h 1 1 0 1", m_valid, m_data[63:0], m_ws, m_last, s0_ready, cnt1, b[63:0]);
    end
  endtask

  task automatic test_odd();
    int cyc;
    logic [DW-1:0] d;
    do_reset();
    for (int b = 1; b <= 3; b++) begin
      d = rnd_wide();
      push(0, d, b == 3, 0, cyc);
      checks++;
      if (m_data !== d || err_odd !== (b == 3)) begin
        errors++; $display("FAIL odd_beat%0d got d=%0h err=%b need %0h %b", b, m_data[63:0], err_odd, d[63:0], b == 3);
      end
    end
    s0_valid = 0;
    for (int b = 0; b < 2; b++) push(1, DW'(b), b == 1, 0, cyc);
    s1_valid = 0;
    checks++;
    if (err_odd !== 1'b1 || cnt1 !== 16'd1) begin errors++; $display("FAIL odd_sticky got err=%b c1=%0d need 1 1", err_odd, cnt1); end
    do_reset();
    d = rnd_wide();
    push(0, d, 1, 0, cyc);
    s0_valid = 0;
    checks++;
    if (cnt0 !== 16'd1 || err_odd !== 1'b1 || m_last !== 1'b1 || m_data !== d) begin
      errors++; $display("FAIL odd_single got c0=%0d err=%b l=%b d=%0h need 1 1 1 %0h", cnt0, err_odd, m_last, m_data[63:0], d[63:0]);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    do_reset();
    for (int b = 1; b <= 2; b++) push(0, DW'(b), 0, 0, cyc);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({m_valid, m_last, m_ws, s0_ready, s1_ready, grant, err_odd} !== 8'b0 || m_data !== '0 || cnt0 !== '0) begin
      errors++; $display("FAIL arst_mid got v=%b d=%0h g=%b r0=%b need all zero", m_valid, m_data[63:0], grant, s0_ready);
    end
    idle_in();
    @(negedge clk);
    rst_n = 1;
    push(0, DW'(9), 0, 0, cyc);
    checks++;
    if (cyc !== 2 || grant !== 2'b01 || m_data !== DW'(9)) begin
      errors++; $display("FAIL arst_regrant got cyc=%0d g=%b d=%0h need 2 01 9", cyc, grant, m_data[63:0]);
    end
    push(0, DW'(10), 1, 0, cyc);
    s0_valid = 0;
    checks++;
    if (cnt0 !== 16'd1 || err_odd !== 1'b0) begin errors++; $display("FAIL arst_after got c0=%0d err=%b need 1 0", cnt0, err_odd); end
  endtask

  // model: whole packets granted by the arbitration rules, output stream = granted packets in order
  task automatic test_random();
    logic [DW-1:0] pd[2][6];
    logic pw[2][6];
    int len[2], idx[2], ncnt[2];
    logic v[2], acc[2];
    logic merr, mlast;
    int pend, w, pops;
    beat_t exp_q[$];
    beat_t e;
    do_reset();
    merr = 0; mlast = 1; pend = -1; pops = 0;
    for (int s = 0; s < 2; s++) begin
      ncnt[s] = 0; v[s] = 0; idx[s] = 0; len[s] = 1 + $urandom_range(0, 4);
      for (int b = 0; b < 6; b++) begin pd[s][b] = rnd_wide(); pw[s][b] = s == 1 ? 1'($urandom_range(0, 1)) : 1'b0; end
    end
    for (int c = 0; c < 3000; c++) begin
      m_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) cfg_prio = ~cfg_prio;
      for (int s = 0; s < 2; s++) if (!v[s] && $urandom_range(0, 2) != 0) v[s] = 1;
      s0_valid = v[0]; s0_data = pd[0][idx[0]]; s0_last = idx[0] == len[0] - 1;
      s1_valid = v[1]; s1_data = pd[1][idx[1]]; s1_last = idx[1] == len[1] - 1; s1_ws = pw[1][idx[1]];
      #1;
      checks++;
      if ((s0_ready && s1_ready) || (grant == 2'b00 && (s0_ready || s1_ready))) begin
        errors++; $display("FAIL rnd_ready c=%0d got r0=%b r1=%b g=%b", c, s0_ready, s1_ready, grant);
      end
      if (pend >= 0) begin
        checks++;
        if (grant !== (pend == 1 ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rnd_grant c=%0d got %b need %b", c, grant, pend == 1 ? 2'b10 : 2'b01);
        end
        pend = -1;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra c=%0d got unexpected beat d=%0h", c, m_data[63:0]);
        end else begin
          e = exp_q.pop_front();
          pops++;
          if (m_data !== e.d || m_last !== e.l || m_ws !== e.t) begin
            errors++; $display("FAIL rnd_beat c=%0d got d=%0h l=%b ws=%b need %0h %b %b", c, m_data[63:0], m_last, m_ws, e.d[63:0], e.l, e.t);
          end
        end
      end
      if (grant == 2'b00 && (v[0] || v[1])) begin
        w = v[0] && v[1] ? (cfg_prio ? 1 : (mlast ? 0 : 1)) : (v[1] ? 1 : 0);
        mlast = w[0];
        pend = w;
        for (int b = 0; b < len[w]; b++) begin
          e.d = pd[w][b]; e.l = b == len[w] - 1; e.t = pw[w][b];
          exp_q.push_back(e);
        end
      end
      acc[0] = v[0] && s0_ready;
      acc[1] = v[1] && s1_ready;
      @(negedge clk);
      for (int s = 0; s < 2; s++) if (acc[s]) begin
        if (idx[s] == len[s] - 1) begin
          ncnt[s]++;
          if (len[s] % 2 == 1) merr = 1;
          idx[s] = 0; len[s] = 1 + $urandom_range(0, 4);
          for (int b = 0; b < 6; b++) begin pd[s][b] = rnd_wide(); pw[s][b] = s == 1 ? 1'($urandom_range(0, 1)) : 1'b0; end
        end else begin
          idx[s]++;
        end
        v[s] = 1'($urandom_range(0, 1));
      end
    end
    idle_in();
    checks++;
    if (cnt0 !== CW'(ncnt[0]) || cnt1 !== CW'(ncnt[1]) || err_odd !== merr) begin
      errors++; $display("FAIL rnd_totals got c0=%0d c1=%0d err=%b need %0d %0d %b", cnt0, cnt1, err_odd, ncnt[0], ncnt[1], merr);
    end
    checks++;
    if (pops < 100) begin errors++; $display("FAIL rnd_traffic got %0d output beats need at least 100", pops); end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_round_robin();
    test_prio();
    test_stall();
    test_odd();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
